// File: rtl/tx_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tx_frame_scheduler
//  Purpose  : Shares one UART byte transmitter between NUM_SRC message
//             producers. Pending requests are arbitrated round-robin. The
//             winning message is latched and sent as a 3-byte frame
//             (i, j, status) over the send/txdone byte handshake.
//  Ports    : clk          - system clock, rising edge
//             rst          - synchronous active-high reset
//             req          - per-source request, held until granted
//             msg_in       - packed messages, source k at [k*MW +: MW]
//             grant        - one-hot one-cycle pulse, message consumed
//             txdata       - byte to UART TX, stable from send to txdone
//             send         - one-cycle pulse, start transmitting txdata
//             txdone       - one-cycle pulse from UART TX, byte finished
//             busy         - high while a frame is in flight
//             timeout_err  - one-cycle pulse when a frame is aborted
//  Revision : 1.0 - initial release
// ============================================================================
module tx_frame_scheduler #(
    parameter int NUM_SRC    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_SRC-1:0]                        req,
    input  logic [NUM_SRC*(2*(ADDR_WIDTH+1)+4)-1:0]   msg_in,
    output logic [NUM_SRC-1:0]                        grant,
    output logic [7:0]                                txdata,
    output logic                                      send,
    input  logic                                      txdone,
    output logic                                      busy,
    output logic                                      timeout_err
);

    localparam int MW = 2*(ADDR_WIDTH+1)+4;
    localparam int FW = ADDR_WIDTH+1;
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT-1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t               state_q;
    logic [PW-1:0]        ptr_q;
    logic [1:0]           idx_q;
    logic [TW-1:0]        timer_q;
    logic [MW-1:0]        msg_q;
    logic [NUM_SRC-1:0]   grant_q;
    logic [7:0]           txdata_q;
    logic                 send_q;
    logic                 busy_q;
    logic                 timeout_err_q;

    // ------------------------------------------------------------------
    // Round-robin search. Requests are rotated so that bit 0 of the
    // rotated vector corresponds to the source at the pointer; the first
    // set bit upward is the winner.
    // ------------------------------------------------------------------
    logic [2*NUM_SRC-1:0] w_rot;
    logic                 w_found;
    logic [PW-1:0]        w_win;
    logic [NUM_SRC-1:0]   w_onehot;
    logic [MW-1:0]        w_msg;
    logic [PW-1:0]        w_next_ptr;

    always_comb begin
        w_rot      = {req, req} >> ptr_q;
        w_found    = 1'b0;
        w_win      = '0;
        w_onehot   = '0;
        w_msg      = '0;
        w_next_ptr = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_win   = PW'((int'(ptr_q) + k) % NUM_SRC);
            end
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            if (w_win == PW'(k)) begin
                w_msg       = msg_in[k*MW +: MW];
                w_onehot[k] = w_found;
            end
        end
        if (w_win != PW'(NUM_SRC-1)) begin
            w_next_ptr = w_win + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            idx_q         <= '0;
            timer_q       <= '0;
            msg_q         <= '0;
            grant_q       <= '0;
            txdata_q      <= '0;
            send_q        <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            grant_q       <= '0;
            send_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_found) begin
                        grant_q  <= w_onehot;
                        send_q   <= 1'b1;
                        txdata_q <= 8'(w_msg[MW-1 -: FW]);
                        msg_q    <= w_msg;
                        busy_q   <= 1'b1;
                        idx_q    <= '0;
                        timer_q  <= '0;
                        ptr_q    <= w_next_ptr;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A txdone coincident with our own send pulse belongs to
                    // no byte of ours and is dropped.
                    if (txdone && !send_q) begin
                        if (idx_q == 2'd2) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            send_q   <= 1'b1;
                            txdata_q <= (idx_q == 2'd0) ? 8'(msg_q[MW-FW-1 -: FW])
                                                        : 8'(msg_q[3:0]);
                            idx_q    <= idx_q + 2'd1;
                            timer_q  <= '0;
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        // Message was already granted, so it is dropped here.
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grant       = grant_q;
    assign txdata      = txdata_q;
    assign send        = send_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
- Shares the single UART transmitter between NUM_SRC message producers (board cells / cell-side buffer queues).
- Arbitrates round-robin among pending requests and latches the winning message.
- Serialises the latched message as a 3-byte frame (i, j, status) over the byte-level send/txdone handshake.
- Sits between the cell message fabric and the UART TX byte engine.

Parameters:
- NUM_SRC, 4, number of requesters (1..16).
- ADDR_WIDTH, 4, board coordinate width. MESSAGE_WIDTH = 2*(ADDR_WIDTH+1)+4. ADDR_WIDTH+1 must be <= 8.
- TIMEOUT, 65535, max cycles to wait for txdone per byte before aborting the frame (>= 2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_SRC  per-source request; source holds req and its msg stable until granted.
- msg_in  in  NUM_SRC*MESSAGE_WIDTH  source k message at bits [k*MESSAGE_WIDTH +: MESSAGE_WIDTH].
- grant  out  NUM_SRC  one-hot, one-cycle pulse; message consumed; source may drop req or present the next msg.
- txdata  out  8  byte to UART TX; stable from send until the matching txdone.
- send  out  1  one-cycle pulse: start transmitting txdata.
- txdone  in  1  one-cycle pulse from UART TX: byte finished.
- busy  out  1  high while a frame is in flight.
- timeout_err  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: grant=0, txdata=0, send=0, busy=0, timeout_err=0, state=IDLE, rr pointer=0, byte index=0, timer=0. All outputs are registered.
- Message fields: i = msg[MW-1 -: AW+1], j = msg[MW-AW-2 -: AW+1], status = msg[3:0].
- Frame bytes, each zero-extended to 8 bits: byte0 = i, byte1 = j, byte2 = status.
- States: IDLE, WAIT.
- IDLE, if req != 0 at edge t:
  - Winner = first set req bit searching upward from the rr pointer, wrapping modulo NUM_SRC.
  - Latch the winner's msg.
  - Registered effects at edge t: grant[winner]=1, send=1, txdata=byte0, busy=1, idx=0, timer=0, rr pointer = (winner+1) mod NUM_SRC.
  - Next state WAIT. grant and send are therefore both high in the cycle after the request is sampled (latency 1).
- IDLE, if req == 0: no change.
- WAIT:
  - grant=0, send=0 after their one-cycle pulse.
  - txdone is ignored in any cycle where send is high.
  - timer increments each cycle.
  - txdone with idx<2: send=1, txdata=next byte, idx++, timer=0. The next byte's send comes on the cycle after txdone.
  - txdone with idx==2: busy=0, state IDLE. A new arbitration may occur on the following edge, so there is a minimum 1 idle cycle between frames.
  - timer reaches TIMEOUT-1 without txdone: timeout_err=1 for one cycle, busy=0, state IDLE. The message is dropped; it has already been granted.
- req dropped before grant: legal, no side effect.
- req toggling during WAIT: ignored; it is evaluated only in IDLE.
- msg_in changes after grant: no effect on the frame in flight.
- Single requester asserting continuously: served every frame. The pointer wraps past it and returns to it.
- NUM_SRC==1: degenerates to a pass-through with the same timing.
- rst mid-frame: immediate return to reset values on that edge. The partial frame is abandoned, no timeout_err, and the granted message is lost.

Test Plan:
- Single frame: NUM_SRC=4, ADDR_WIDTH=4; req=0001, msg0={5'd5,5'd9,4'hA}.
  - Required: grant=0001 and send=1 with txdata=0x05 on cycle +1.
  - Bench returns txdone 3 cycles after each send; required sends with 0x09 then 0x0A, each 1 cycle after txdone.
  - busy falls on the cycle after the third txdone.
- Round-robin: req=1111 held, every source re-requesting immediately after grant. Required: grant order 0001, 0010, 0100, 1000, 0001.
- Pointer skip: after serving source 1, req=0011. Required: next grant=0001, since the search starts at 2 and wraps to 0.
- Timeout: TIMEOUT=16, bench never returns txdone. Required: timeout_err pulses 16 cycles after send, busy=0, and the next req is accepted normally.
- Stale txdone: txdone asserted in the same cycle as send. Required: it is ignored; the next byte is issued only on a later txdone.
- Reset mid-frame: rst pulsed after byte1 send. Required: next cycle all outputs 0, pointer=0; req=1000 then gets grant=1000 with byte0 re-framed from scratch.
